// File: rtl/nibble_pkg.sv
// Shared types and defaults for the nibble packer.
package nibble_pkg;

  localparam int DATA_W_DEF  = 4;
  localparam int NIBBLES_DEF = 4;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } pack_state_t;

  typedef logic [DATA_W_DEF-1:0] nibble_t;

endpackage

// File: rtl/nibble_packer.sv
// Pops nibbles from a show-ahead FIFO and packs NIBBLES of them (first popped
// in the LSBs) into one word presented on a valid/ready interface. A flush
// emits a partially filled word together with its nibble count.
module nibble_packer
  import nibble_pkg::*;
#(
  parameter  int DATA_W  = DATA_W_DEF,
  parameter  int NIBBLES = NIBBLES_DEF,
  localparam int CNT_W   = $clog2(NIBBLES + 1),
  localparam int WORD_W  = DATA_W * NIBBLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              fifo_rd_en,
  input  logic              flush,
  output logic [WORD_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_nvalid,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  pack_state_t       state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [WORD_W-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0]  out_nvalid_q, out_nvalid_d;
  logic              out_valid_q, out_valid_d;

  logic              pop;
  logic [WORD_W-1:0] filled;

  // Pop whenever collecting and the FIFO has data; never pops while holding.
  assign pop        = (state_q == COLLECT) && !fifo_empty;
  assign fifo_rd_en = pop;

  assign out_data   = out_data_q;
  assign out_nvalid = out_nvalid_q;
  assign out_valid  = out_valid_q;
  assign busy       = (count_q != '0) || out_valid_q;

  // Partial word with the nibble being popped this cycle merged into its slot.
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    filled = shift_q;
    if (pop) begin
      filled[int'(count_q)*DATA_W +: DATA_W] = fifo_rd_data;
    end
  end

  // Next-state logic: collect nibbles, emit full/flushed words, await handshake.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    shift_d      = shift_q;
    out_data_d   = out_data_q;
    out_nvalid_d = out_nvalid_q;
    out_valid_d  = out_valid_q;

    unique case (state_q)
      COLLECT: begin
        if (pop && (count_q == CNT_W'(NIBBLES - 1))) begin
          out_data_d   = filled;
          out_nvalid_d = CNT_W'(NIBBLES);
          out_valid_d  = 1'b1;
          count_d      = '0;
          shift_d      = filled;
          state_d      = HOLD;
        end else if (flush && (pop || (count_q != '0))) begin
          // Unfilled slots are already zero because the shift register is
          // cleared at every handshake and on reset.
          out_data_d   = filled;
          out_nvalid_d = pop ? (count_q + CNT_W'(1)) : count_q;
          out_valid_d  = 1'b1;
          count_d      = '0;
          shift_d      = filled;
          state_d      = HOLD;
        end else if (pop) begin
          shift_d = filled;
          count_d = count_q + CNT_W'(1);
        end
      end
      HOLD: begin
        // Flush is ignored here; out_data keeps its value past the handshake.
        if (out_ready) begin
          out_valid_d  = 1'b0;
          out_nvalid_d = '0;
          shift_d      = '0;
          state_d      = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // State registers with synchronous reset; reset drops any held or partial word.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block evaluation order.
    if (rst) begin
      state_q      <= COLLECT;
      count_q      <= '0;
      shift_q      <= '0;
      out_data_q   <= '0;
      out_nvalid_q <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      shift_q      <= shift_d;
      out_data_q   <= out_data_d;
      out_nvalid_q <= out_nvalid_d;
      out_valid_q  <= out_valid_d;
    end
  end

  // Protocol properties.
  a_no_pop_on_empty: assert property (@(posedge clk) disable iff (rst)
    !(fifo_rd_en && fifo_empty));

  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> ($stable(out_data) && $stable(out_nvalid) && out_valid));

  a_nvalid_range: assert property (@(posedge clk) disable iff (rst)
    out_valid |-> ((out_nvalid >= CNT_W'(1)) && (out_nvalid <= CNT_W'(NIBBLES))));

endmodule
